// File: rtl/retire_pkg.sv
// Shared types for the in-order retirement stage.
// Holds the ROB head entry layout, FSM states and stop kinds.
package retire_pkg;

    localparam int CW = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } retire_state_e;

    typedef enum logic [1:0] {
        STOP_NONE    = 2'd0,
        STOP_MISPRED = 2'd1,
        STOP_EBREAK  = 2'd2
    } stop_kind_e;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        rd_en;
        logic [4:0]  rd;
        logic [7:0]  prd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        mispred;
        logic [31:0] tgt;
        logic        ebreak;
    } rob_head_t;

endpackage

// File: rtl/retire_select.sv
// Picks the longest ready in-order prefix of the four ROB heads.
// A mispredict or ebreak slot retires and ends the group.
module retire_select
    import retire_pkg::*;
(
    input  logic          en,
    input  logic [CW-1:0] valid,
    input  logic [CW-1:0] done,
    input  logic [CW-1:0] mispred,
    input  logic [CW-1:0] ebreak,
    output logic [CW-1:0] commit,
    output logic [2:0]    pop,
    output logic [1:0]    stop_idx,
    output stop_kind_e    stop_kind
);

    // Walk slots oldest-first; the chain breaks on a not-ready or flagged slot.
    always_comb begin
        logic open;
        commit    = '0;
        pop       = '0;
        stop_idx  = '0;
        stop_kind = STOP_NONE;
        open      = en;
        for (int k = 0; k < CW; k++) begin
            if (open && valid[k] && done[k]) begin
                commit[k] = 1'b1;
                pop       = pop + 3'd1;
                if (ebreak[k]) begin
                    open      = 1'b0;
                    stop_idx  = 2'(k);
                    stop_kind = STOP_EBREAK;
                end else if (mispred[k]) begin
                    open      = 1'b0;
                    stop_idx  = 2'(k);
                    stop_kind = STOP_MISPRED;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/retire_unit.sv
// In-order retirement: pop count, registered commit bundle,
// committed-RAT writes, flush/halt sequencing and retire counter.
module retire_unit #(
    parameter int PREG_W = 8,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     rob_valid_i,
    input  logic [CW-1:0]     rob_done_i,
    input  logic [CW-1:0]     rob_rd_en_i,
    input  logic [4:0]        rob_rd_i      [CW],
    input  logic [PREG_W-1:0] rob_prd_i     [CW],
    input  logic [31:0]       rob_data_i    [CW],
    input  logic [31:0]       rob_pc_i      [CW],
    input  logic [CW-1:0]     rob_mispred_i,
    input  logic [31:0]       rob_tgt_i     [CW],
    input  logic [CW-1:0]     rob_ebreak_i,
    output logic [2:0]        rob_pop_o,
    output logic [7:0]        valid_o,
    output logic [7:0]        rat_write_en_o,
    output logic [7:0]        rat_write_addr_o [CW],
    output logic [7:0]        rat_write_data_o [CW],
    output logic [31:0]       reg_write_data_o [CW],
    output logic [31:0]       pc_o             [CW],
    output logic              flush_o,
    output logic [31:0]       redirect_pc_o,
    output logic              halt_o,
    output logic [63:0]       retired_cnt_o
);

    import retire_pkg::*;

    retire_state_e state_q;
    retire_state_e state_d;
    rob_head_t     head [CW];
    logic [CW-1:0] sel_valid;
    logic [CW-1:0] sel_done;
    logic [CW-1:0] sel_mispred;
    logic [CW-1:0] sel_ebreak;
    logic [CW-1:0] commit;
    logic [2:0]    pop;
    logic [1:0]    stop_idx;
    stop_kind_e    stop_kind;
    logic          sel_en;

    logic [CW-1:0] valid_q;
    logic [CW-1:0] rat_en_q;
    logic [7:0]    addr_q [CW];
    logic [7:0]    prd_q  [CW];
    logic [31:0]   data_q [CW];
    logic [31:0]   pc_q   [CW];
    logic [31:0]   redir_q;
    logic [63:0]   cnt_q;

    // Gather the per-slot ROB ports into one entry view.
    always_comb begin
        for (int k = 0; k < CW; k++) begin
            head[k].valid   = rob_valid_i[k];
            head[k].done    = rob_done_i[k];
            head[k].rd_en   = rob_rd_en_i[k];
            head[k].rd      = rob_rd_i[k];
            head[k].prd     = 8'(rob_prd_i[k]);
            head[k].data    = rob_data_i[k];
            head[k].pc      = rob_pc_i[k];
            head[k].mispred = rob_mispred_i[k];
            head[k].tgt     = rob_tgt_i[k];
            head[k].ebreak  = rob_ebreak_i[k];
            sel_valid[k]    = head[k].valid;
            sel_done[k]     = head[k].done;
            sel_mispred[k]  = head[k].mispred;
            sel_ebreak[k]   = head[k].ebreak;
        end
    end

    // Retirement only happens in RUN and never while reset is held.
    assign sel_en = (state_q == RUN) && !rst;

    retire_select u_select (
        .en        (sel_en),
        .valid     (sel_valid),
        .done      (sel_done),
        .mispred   (sel_mispred),
        .ebreak    (sel_ebreak),
        .commit    (commit),
        .pop       (pop),
        .stop_idx  (stop_idx),
        .stop_kind (stop_kind)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state: flagged retire leaves RUN; FLUSH lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (stop_kind == STOP_EBREAK)       state_d = HALT;
                else if (stop_kind == STOP_MISPRED) state_d = FLUSH;
            end
            FLUSH:   state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Commit bundle, redirect target and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rat_en_q <= '0;
            redir_q  <= '0;
            cnt_q    <= '0;
            for (int k = 0; k < CW; k++) begin
                addr_q[k] <= '0;
                prd_q[k]  <= '0;
                data_q[k] <= '0;
                pc_q[k]   <= '0;
            end
        end else begin
            valid_q <= commit;
            cnt_q   <= cnt_q + 64'(pop);
            for (int k = 0; k < CW; k++) begin
                rat_en_q[k] <= commit[k] && head[k].rd_en
                               && (head[k].rd != 5'd0);
                addr_q[k] <= commit[k] ? {3'b0, head[k].rd} : 8'd0;
                prd_q[k]  <= commit[k] ? head[k].prd : 8'd0;
                data_q[k] <= commit[k] ? head[k].data : 32'd0;
                pc_q[k]   <= commit[k] ? head[k].pc : 32'd0;
            end
            if (stop_kind == STOP_MISPRED)
                redir_q <= head[stop_idx].tgt;
        end
    end

    assign rob_pop_o        = pop;
    assign valid_o          = {4'b0, valid_q};
    assign rat_write_en_o   = {4'b0, rat_en_q};
    assign rat_write_addr_o = addr_q;
    assign rat_write_data_o = prd_q;
    assign reg_write_data_o = data_q;
    assign pc_o             = pc_q;
    assign flush_o          = (state_q == FLUSH);
    assign redirect_pc_o    = redir_q;
    assign halt_o           = (state_q == HALT);
    assign retired_cnt_o    = cnt_q;

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit with a per-cycle reference model
// of in-order retirement, flush and halt behaviour.
module tb_retire_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  v, d, re, mp, eb;
    logic [4:0]  rd  [4];
    logic [7:0]  prd [4];
    logic [31:0] dat [4];
    logic [31:0] pcs [4];
    logic [31:0] tg  [4];

    logic [2:0]  rob_pop_o;
    logic [7:0]  valid_o, rat_write_en_o;
    logic [7:0]  rat_write_addr_o [4];
    logic [7:0]  rat_write_data_o [4];
    logic [31:0] reg_write_data_o [4];
    logic [31:0] pc_o [4];
    logic        flush_o, halt_o;
    logic [31:0] redirect_pc_o;
    logic [63:0] retired_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;
    bit pre_req = 0;
    logic [63:0] pre_val = '0;

    // model state: 0 running, 1 flushing, 2 halted
    int          m_mode;
    logic [63:0] m_cnt;
    logic [3:0]  m_valid, m_rat;
    logic [7:0]  m_addr [4];
    logic [7:0]  m_prd  [4];
    logic [31:0] m_dat  [4];
    logic [31:0] m_pc   [4];
    logic [31:0] m_redir;

    always #5 clk = ~clk;

    retire_unit #(.PREG_W(8), .CW(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .rob_valid_i      (v),
        .rob_done_i       (d),
        .rob_rd_en_i      (re),
        .rob_rd_i         (rd),
        .rob_prd_i        (prd),
        .rob_data_i       (dat),
        .rob_pc_i         (pcs),
        .rob_mispred_i    (mp),
        .rob_tgt_i        (tg),
        .rob_ebreak_i     (eb),
        .rob_pop_o        (rob_pop_o),
        .valid_o          (valid_o),
        .rat_write_en_o   (rat_write_en_o),
        .rat_write_addr_o (rat_write_addr_o),
        .rat_write_data_o (rat_write_data_o),
        .reg_write_data_o (reg_write_data_o),
        .pc_o             (pc_o),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o),
        .halt_o           (halt_o),
        .retired_cnt_o    (retired_cnt_o)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Retire oldest-first until a slot is not ready; a flagged slot is last.
    function automatic void walk(output logic [3:0] cm, output logic [2:0] n,
                                 output int stop, output logic [31:0] t);
        cm = 0; n = 0; stop = 0; t = 0;
        for (int k = 0; k < 4; k++) begin
            if (!(v[k] && d[k])) break;
            cm[k] = 1'b1;
            n = n + 3'd1;
            if (eb[k]) begin stop = 2; break; end
            if (mp[k]) begin stop = 1; t = tg[k]; break; end
        end
    endfunction

    always @(posedge clk) begin : model
        logic [3:0]  cm;
        logic [2:0]  n;
        int          stop;
        logic [31:0] t;
        logic [63:0] base;
        walk(cm, n, stop, t);
        base = pre_req ? pre_val : m_cnt;
        if (rst) begin
            m_mode <= 0; m_cnt <= 0; m_valid <= 0; m_rat <= 0; m_redir <= 0;
            for (int k = 0; k < 4; k++) begin
                m_addr[k] <= 0; m_prd[k] <= 0; m_dat[k] <= 0; m_pc[k] <= 0;
            end
        end else if (m_mode != 0) begin
            m_mode <= (m_mode == 1) ? 0 : 2;
            m_cnt <= base;
            m_valid <= 0; m_rat <= 0;
            for (int k = 0; k < 4; k++) begin
                m_addr[k] <= 0; m_prd[k] <= 0; m_dat[k] <= 0; m_pc[k] <= 0;
            end
        end else begin
            m_cnt <= base + 64'(n);
            m_valid <= cm;
            for (int k = 0; k < 4; k++) begin
                m_rat[k]  <= cm[k] && re[k] && (rd[k] != 0);
                m_addr[k] <= cm[k] ? {3'b0, rd[k]} : 8'd0;
                m_prd[k]  <= cm[k] ? prd[k] : 8'd0;
                m_dat[k]  <= cm[k] ? dat[k] : 32'd0;
                m_pc[k]   <= cm[k] ? pcs[k] : 32'd0;
            end
            if (stop == 2) m_mode <= 2;
            else if (stop == 1) begin m_mode <= 1; m_redir <= t; end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0]  cm;
        logic [2:0]  n;
        int          stop;
        logic [31:0] t;
        if (chk_on) begin
            walk(cm, n, stop, t);
            check("pop", 64'(rob_pop_o),
                  (rst || m_mode != 0) ? 64'd0 : 64'(n));
            check("valid", 64'(valid_o), {60'd0, m_valid});
            check("rat_en", 64'(rat_write_en_o), {60'd0, m_rat});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rat_addr%0d", k),
                      64'(rat_write_addr_o[k]), 64'(m_addr[k]));
                check($sformatf("rat_data%0d", k),
                      64'(rat_write_data_o[k]), 64'(m_prd[k]));
                check($sformatf("reg_data%0d", k),
                      64'(reg_write_data_o[k]), 64'(m_dat[k]));
                check($sformatf("pc%0d", k), 64'(pc_o[k]), 64'(m_pc[k]));
            end
            check("flush", 64'(flush_o), 64'(m_mode == 1));
            check("halt", 64'(halt_o), 64'(m_mode == 2));
            check("redirect", 64'(redirect_pc_o), 64'(m_redir));
            if (!pre_req) check("cnt", retired_cnt_o, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rob();
        v = 0; d = 0; re = 0; mp = 0; eb = 0;
        for (int k = 0; k < 4; k++) begin
            rd[k] = 0; prd[k] = 0; dat[k] = 0; pcs[k] = 0; tg[k] = 0;
        end
    endtask

    task automatic fill(input logic [3:0] vm, input logic [3:0] dm);
        clear_rob();
        v = vm; d = dm; re = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rd[k]  = 5'(k + 1);
            prd[k] = 8'(8'h10 + k);
            dat[k] = 32'hD000_0000 + 32'(k);
            pcs[k] = 32'h8000_0000 + 32'(4 * k);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_rob();
        step();
        step();
        chk_on = 1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_cnt", retired_cnt_o, 64'd0);
        check("rst_halt", 64'(halt_o), 64'd0);
        check("rst_flush", 64'(flush_o), 64'd0);
        rst = 1'b0;

        fill(4'hF, 4'hF);
        #1 check("t1_pop", 64'(rob_pop_o), 64'd4);
        step();
        check("t1_valid", 64'(valid_o), 64'h0F);
        check("t1_rat", 64'(rat_write_en_o), 64'h0F);
        check("t1_cnt", retired_cnt_o, 64'd4);
        check("t1_addr3", 64'(rat_write_addr_o[3]), 64'd4);

        fill(4'hF, 4'b1011);
        #1 check("t2_pop", 64'(rob_pop_o), 64'd2);
        step();
        check("t2_valid", 64'(valid_o), 64'h03);
        check("t2_pc3", 64'(pc_o[3]), 64'd0);

        fill(4'h3, 4'h3);
        rd[0] = 0; re[1] = 0;
        step();
        check("t3_valid", 64'(valid_o), 64'h03);
        check("t3_rat", 64'(rat_write_en_o), 64'h00);
        check("t3_cnt", retired_cnt_o, 64'd8);

        fill(4'hF, 4'hF);
        mp[1] = 1; tg[1] = 32'h8000_0100;
        #1 check("t4_pop", 64'(rob_pop_o), 64'd2);
        step();
        check("t4_flush", 64'(flush_o), 64'd1);
        check("t4_redir", 64'(redirect_pc_o), 64'h8000_0100);
        check("t4_valid", 64'(valid_o), 64'h03);
        check("t4_pop_fl", 64'(rob_pop_o), 64'd0);
        step();
        check("t4_flush0", 64'(flush_o), 64'd0);
        check("t4_valid0", 64'(valid_o), 64'd0);
        check("t4_pop_run", 64'(rob_pop_o), 64'd2);
        check("t4_cnt", retired_cnt_o, 64'd10);
        clear_rob();

        v = 0; d = 4'hF; mp = 4'h1; eb = 4'h1;
        #1 check("t5_pop", 64'(rob_pop_o), 64'd0);
        step();
        check("t5_valid", 64'(valid_o), 64'd0);

        fill(4'hF, 4'hF);
        mp[2] = 1; eb[2] = 1; tg[2] = 32'h1234_5678;
        #1 check("t6_pop", 64'(rob_pop_o), 64'd3);
        step();
        check("t6_halt", 64'(halt_o), 64'd1);
        check("t6_flush", 64'(flush_o), 64'd0);
        check("t6_valid", 64'(valid_o), 64'h07);
        check("t6_redir", 64'(redirect_pc_o), 64'h8000_0100);
        repeat (3) step();
        check("t6_pop_h", 64'(rob_pop_o), 64'd0);
        check("t6_cnt", retired_cnt_o, 64'd13);
        rst = 1'b1;
        step();
        check("t6_rhalt", 64'(halt_o), 64'd0);
        check("t6_rcnt", retired_cnt_o, 64'd0);
        rst = 1'b0;

        fill(4'hF, 4'hF);
        eb[0] = 1;
        #1 check("t7_pop", 64'(rob_pop_o), 64'd1);
        step();
        check("t7_halt", 64'(halt_o), 64'd1);
        check("t7_valid", 64'(valid_o), 64'h01);
        check("t7_cnt", retired_cnt_o, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        fill(4'h1, 4'h1);
        mp[0] = 1; tg[0] = 32'hCAFE_0000;
        step();
        check("t8_flush", 64'(flush_o), 64'd1);
        rst = 1'b1;
        step();
        check("t8_flush0", 64'(flush_o), 64'd0);
        check("t8_redir", 64'(redirect_pc_o), 64'd0);
        rst = 1'b0;
        clear_rob();
        step();

        pre_val = 64'hFFFF_FFFF_FFFF_FFFE;
        pre_req = 1;
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.cnt_q;
        fill(4'hF, 4'hF);
        step();
        pre_req = 0;
        check("t9_wrap", retired_cnt_o, 64'd2);
        clear_rob();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/retire_unit.md
# retire_unit

In-order retirement stage of the out-of-order core: examines the four oldest ROB entries each cycle and retires the longest ready in-order prefix. It drives the ROB pop count, updates the committed RAT, and produces the registered per-cycle commit bundle that feeds the simulation commit monitor. It also handles mispredict flush and ebreak halt sequencing, and keeps a retired-instruction counter.

## Interface
- `PREG_W`, 8: physical register index width; must be ≤ 8.
- `CW`, 4: commit width, fixed at 4 (bundle format depends on it).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rob_valid_i[k]` in 1 ×4: ROB head+k holds an instruction.
- `rob_done_i[k]` in 1 ×4: entry k has completed execution.
- `rob_rd_en_i[k]` in 1 ×4: entry k writes a destination register.
- `rob_rd_i[k]` in 5 ×4: architectural destination.
- `rob_prd_i[k]` in PREG_W ×4: physical destination.
- `rob_data_i[k]` in 32 ×4: result value.
- `rob_pc_i[k]` in 32 ×4: instruction PC.
- `rob_mispred_i[k]` in 1 ×4: branch mispredicted.
- `rob_tgt_i[k]` in 32 ×4: correct target for a mispredicted branch.
- `rob_ebreak_i[k]` in 1 ×4: instruction is ebreak.
- `rob_pop_o` out 3: entries retired this cycle (0–4). Combinational.
- `valid_o` out 8: bit k = slot k committed; bits 7:4 = 0.
- `rat_write_en_o` out 8: bit k = slot k writes the RAT; bits 7:4 = 0.
- `rat_write_addr_o[k]` out 8 ×4: architectural rd, zero-extended.
- `rat_write_data_o[k]` out 8 ×4: physical rd, zero-extended.
- `reg_write_data_o[k]` out 32 ×4: result value.
- `pc_o[k]` out 32 ×4: PC of slot k.
- `flush_o` out 1: pipeline flush pulse.
- `redirect_pc_o` out 32: fetch redirect target, valid with `flush_o`.
- `halt_o` out 1: ebreak retired; sticky.
- `retired_cnt_o` out 64: total instructions retired.

## Operation
- FSM states RUN, FLUSH, HALT. Reset state is RUN.
- In RUN, slot k commits iff:
  - slots 0..k-1 all commit, and
  - `rob_valid_i[k]` and `rob_done_i[k]` are set, and
  - no earlier committing slot has mispred or ebreak set.
- A mispred or ebreak slot itself commits and is the last slot retired that cycle. If both flags are set on one slot, ebreak wins.
- `rob_pop_o` = number of committing slots. It is 0 in FLUSH and in HALT.
- RAT write for slot k = commit_k & `rob_rd_en_i[k]` & (`rob_rd_i[k]` ≠ 0).
- Transitions:
  - RUN → FLUSH when a committing slot has mispred. Latch `rob_tgt_i` of that slot into `redirect_pc_o`.
  - RUN → HALT when a committing slot has ebreak.
  - FLUSH → RUN after exactly one cycle.
  - HALT is left only by reset.
- `retired_cnt_o` += `rob_pop_o` every cycle. It wraps modulo 2^64.
- Bundle data fields of non-committing slots are don't-care but must not be X. Drive 0.

## Timing
- `rob_pop_o`: same cycle as the decision.
- Bundle fields (`valid_o`, RAT write, data, PC): registered, one cycle after the decision.
- `flush_o`: high for exactly the one FLUSH cycle, which is the cycle after the mispredict retires. It coincides with the bundle that contains the branch. `redirect_pc_o` is held until the next flush.
- `halt_o`: rises the cycle after ebreak retires, coincident with the ebreak bundle, and stays high.
- `retired_cnt_o`: registered. It reflects the pops of the previous cycle, aligned with `valid_o`.
- In FLUSH and in HALT, `valid_o` and `rat_write_en_o` are 0 from the following cycle on.
- Reset: every output is 0. `rst` asserted mid-FLUSH or in HALT forces RUN with all outputs 0 on the next edge.
- `rob_*` inputs with valid = 0 are ignored regardless of the other flags.

## Structure
- `retire_pkg` holds:
  - CW = 4;
  - the `rob_head_t` struct (valid, done, rd_en, rd, prd, data, pc, mispred, tgt, ebreak);
  - the `retire_state_e` enum (RUN, FLUSH, HALT).
- Sub-module `retire_select`: purely combinational prefix and priority logic. Outputs are the commit mask, pop count, stop-slot index and stop kind.
- The top level holds the FSM, bundle registers, redirect register and counter.

## Test plan
- All 4 entries done, no flags, rd = 1..4 → `rob_pop_o` = 4. Next cycle `valid_o` = 0x0F, `rat_write_en_o` = 0x0F, `retired_cnt_o` = 4.
- Slots 0 and 1 done, slot 2 not done, slot 3 done → pop = 2, `valid_o` = 0x03. Slot 3 is not retired.
- Slot 0 rd = 0 with rd_en = 1, slot 1 rd_en = 0 → `valid_o` = 0x03, `rat_write_en_o` = 0x00.
- Slot 1 mispred with tgt 0x80000100, all 4 slots done → pop = 2. Next cycle `flush_o` = 1, `redirect_pc_o` = 0x80000100, `valid_o` = 0x03. Following cycle `flush_o` = 0, pop resumes.
- Slot 0 ebreak → pop = 1, then `halt_o` = 1 and pop = 0 forever. Asserting `rst` clears `halt_o` and `retired_cnt_o` to 0.
- Preload `retired_cnt` to 2^64-2, retire 4 → count = 2.
